arm7tdmi_cp_responder: RTL and testbench

ARM7TDMI_CP_RESPONDER -- requirements
Module: arm7tdmi_cp_responder

---
 rtl/arm7tdmi_pkg.sv | 36 +++
 rtl/arm7tdmi_cp_cdp_alu.sv | 26 ++
 rtl/arm7tdmi_cp_responder.sv | 190 +++++++++++++++++++
 tb/tb_arm7tdmi_cp_responder.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm7tdmi_pkg.sv
// Shared types for the ARM7TDMI coprocessor interface:
// core-side opcodes, responder states and CDP ALU opcodes.
package arm7tdmi_pkg;

    typedef enum logic [2:0] {
        CP_CDP = 3'd0,
        CP_LDC = 3'd1,
        CP_STC = 3'd2,
        CP_MCR = 3'd3,
        CP_MRC = 3'd4
    } cp_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CDP_BUSY,
        ST_MRC_RESP,
        ST_LDC_XFER,
        ST_STC_XFER
    } cp_state_t;

    typedef enum logic [2:0] {
        OPC_ADD  = 3'd0,
        OPC_SUB  = 3'd1,
        OPC_AND  = 3'd2,
        OPC_ORR  = 3'd3,
        OPC_EOR  = 3'd4,
        OPC_MUL  = 3'd5,
        OPC_MOV  = 3'd6,
        OPC_ZERO = 3'd7
    } cdp_opc_t;

    function automatic logic cp_op_known(input logic [2:0] op);
        return op <= 3'd4;
    endfunction

endpackage

// File: rtl/arm7tdmi_cp_cdp_alu.sv
// Combinational CDP datapath; all results wrap modulo 2^32.
module arm7tdmi_cp_cdp_alu
    import arm7tdmi_pkg::*;
(
    input  cdp_opc_t    opc,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [31:0] result
);

    always_comb begin
        result = 32'd0;
        unique case (opc)
            OPC_ADD:  result = op_a + op_b;
            OPC_SUB:  result = op_a - op_b;
            OPC_AND:  result = op_a & op_b;
            OPC_ORR:  result = op_a | op_b;
            OPC_EOR:  result = op_a ^ op_b;
            OPC_MUL:  result = op_a * op_b;
            OPC_MOV:  result = op_a;
            OPC_ZERO: result = 32'd0;
            default:  result = 32'd0;
        endcase
    end

endmodule

// File: rtl/arm7tdmi_cp_responder.sv
// Coprocessor responder: 16-entry register file serving
// CDP, LDC, STC, MCR and MRC with abort support.
module arm7tdmi_cp_responder
    import arm7tdmi_pkg::*;
#(
    parameter logic [3:0] CP_NUM      = 4'd10,
    parameter int         CDP_LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cp_req_valid,
    output logic        cp_req_ready,
    input  logic [2:0]  cp_op,
    input  logic [3:0]  cp_num,
    input  logic [3:0]  cp_crd,
    input  logic [3:0]  cp_crn,
    input  logic [3:0]  cp_crm,
    input  logic [2:0]  cp_opc1,
    input  logic [3:0]  cp_len,
    input  logic [31:0] cp_wdata,
    input  logic        cp_dat_valid,
    output logic        cp_dat_ready,
    output logic [31:0] cp_rdata,
    output logic        cp_rvalid,
    input  logic        cp_rready,
    input  logic        cp_abort,
    output logic        cp_busy,
    output logic        cp_done,
    output logic        cp_absent
);

    localparam logic [3:0] LAT = 4'(CDP_LATENCY);

    cp_state_t   state_q, state_d;
    logic [31:0] cr [16];
    logic [3:0]  idx_q, cnt_q;
    logic [31:0] op_a_q, op_b_q;
    cdp_opc_t    opc_q;
    logic [31:0] alu_res;

    logic        accept, hit;
    logic        done_d, absent_d, rvalid_d;
    logic        wr_en, ld_rdata, step, cnt_dec;
    logic [3:0]  wr_idx, rd_idx;
    logic [31:0] wr_data;

    arm7tdmi_cp_cdp_alu u_alu (
        .opc    (opc_q),
        .op_a   (op_a_q),
        .op_b   (op_b_q),
        .result (alu_res)
    );

    assign cp_req_ready = (state_q == ST_IDLE);
    assign cp_busy      = (state_q != ST_IDLE);
    assign cp_dat_ready = (state_q == ST_LDC_XFER);
    assign accept       = cp_req_valid & cp_req_ready;
    assign hit          = (cp_num == CP_NUM) & cp_op_known(cp_op);

    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        absent_d = 1'b0;
        rvalid_d = cp_rvalid;
        wr_en    = 1'b0;
        wr_idx   = idx_q;
        wr_data  = cp_wdata;
        ld_rdata = 1'b0;
        rd_idx   = idx_q;
        step     = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept && !hit) begin
                    absent_d = 1'b1;
                end else if (accept) begin
                    case (cp_op)
                        CP_MCR: begin
                            wr_en  = 1'b1;
                            wr_idx = cp_crd;
                            done_d = 1'b1;
                        end
                        CP_MRC: begin
                            ld_rdata = 1'b1;
                            rd_idx   = cp_crd;
                            rvalid_d = 1'b1;
                            state_d  = ST_MRC_RESP;
                        end
                        CP_STC: begin
                            ld_rdata = 1'b1;
                            rd_idx   = cp_crd;
                            rvalid_d = 1'b1;
                            state_d  = ST_STC_XFER;
                        end
                        CP_LDC:  state_d = ST_LDC_XFER;
                        default: state_d = ST_CDP_BUSY;
                    endcase
                end
            end
            ST_CDP_BUSY: begin
                if (cp_abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd1) begin
                    wr_en   = 1'b1;
                    wr_data = alu_res;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_MRC_RESP: begin
                if (cp_abort) begin
                    rvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end else if (cp_rready) begin
                    rvalid_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_LDC_XFER: begin
                if (cp_abort) begin
                    state_d = ST_IDLE;
                end else if (cp_dat_valid) begin
                    wr_en   = 1'b1;
                    step    = 1'b1;
                    cnt_dec = 1'b1;
                    if (cnt_q == 4'd0) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_STC_XFER: begin
                if (cp_abort) begin
                    rvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end else if (cp_rready) begin
                    if (cnt_q == 4'd0) begin
                        rvalid_d = 1'b0;
                        done_d   = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        step     = 1'b1;
                        cnt_dec  = 1'b1;
                        ld_rdata = 1'b1;
                        rd_idx   = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= 4'd0;
            cnt_q     <= 4'd0;
            op_a_q    <= 32'd0;
            op_b_q    <= 32'd0;
            opc_q     <= OPC_ADD;
            cp_rdata  <= 32'd0;
            cp_rvalid <= 1'b0;
            cp_done   <= 1'b0;
            cp_absent <= 1'b0;
            for (int i = 0; i < 16; i++) cr[i] <= 32'd0;
        end else begin
            state_q   <= state_d;
            cp_rvalid <= rvalid_d;
            cp_done   <= done_d;
            cp_absent <= absent_d;
            if (wr_en) cr[wr_idx] <= wr_data;
            if (ld_rdata) cp_rdata <= cr[rd_idx];
            // CDP operands are captured here so later MCRs cannot disturb them
            if (accept && hit) begin
                idx_q  <= cp_crd;
                cnt_q  <= (cp_op == CP_CDP) ? LAT : cp_len;
                op_a_q <= cr[cp_crn];
                op_b_q <= cr[cp_crm];
                opc_q  <= cdp_opc_t'(cp_opc1);
            end else begin
                if (step) idx_q <= idx_q + 4'd1;
                if (cnt_dec) cnt_q <= cnt_q - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_arm7tdmi_cp_responder.sv
// Directed self-checking bench for arm7tdmi_cp_responder.
module tb_arm7tdmi_cp_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cp_req_valid = 1'b0;
    logic        cp_req_ready;
    logic [2:0]  cp_op = 3'd0;
    logic [3:0]  cp_num = 4'd10;
    logic [3:0]  cp_crd = 4'd0;
    logic [3:0]  cp_crn = 4'd0;
    logic [3:0]  cp_crm = 4'd0;
    logic [2:0]  cp_opc1 = 3'd0;
    logic [3:0]  cp_len = 4'd0;
    logic [31:0] cp_wdata = 32'd0;
    logic        cp_dat_valid = 1'b0;
    logic        cp_dat_ready;
    logic [31:0] cp_rdata;
    logic        cp_rvalid;
    logic        cp_rready = 1'b0;
    logic        cp_abort = 1'b0;
    logic        cp_busy;
    logic        cp_done;
    logic        cp_absent;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [2:0] OP_CDP = 3'd0;
    localparam logic [2:0] OP_LDC = 3'd1;
    localparam logic [2:0] OP_STC = 3'd2;
    localparam logic [2:0] OP_MCR = 3'd3;
    localparam logic [2:0] OP_MRC = 3'd4;

    arm7tdmi_cp_responder dut (
        .clk          (clk),
        .rst          (rst),
        .cp_req_valid (cp_req_valid),
        .cp_req_ready (cp_req_ready),
        .cp_op        (cp_op),
        .cp_num       (cp_num),
        .cp_crd       (cp_crd),
        .cp_crn       (cp_crn),
        .cp_crm       (cp_crm),
        .cp_opc1      (cp_opc1),
        .cp_len       (cp_len),
        .cp_wdata     (cp_wdata),
        .cp_dat_valid (cp_dat_valid),
        .cp_dat_ready (cp_dat_ready),
        .cp_rdata     (cp_rdata),
        .cp_rvalid    (cp_rvalid),
        .cp_rready    (cp_rready),
        .cp_abort     (cp_abort),
        .cp_busy      (cp_busy),
        .cp_done      (cp_done),
        .cp_absent    (cp_absent)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] num,
                         input logic [3:0] crd, input logic [3:0] crn,
                         input logic [3:0] crm, input logic [2:0] opc1,
                         input logic [3:0] len, input logic [31:0] wdata);
        cp_op = op; cp_num = num; cp_crd = crd; cp_crn = crn;
        cp_crm = crm; cp_opc1 = opc1; cp_len = len; cp_wdata = wdata;
        cp_req_valid = 1'b1;
        cyc();
        cp_req_valid = 1'b0;
    endtask

    task automatic mrc(input logic [3:0] crd, output logic [31:0] d,
                       output logic v, output logic dn);
        issue(OP_MRC, 4'd10, crd, 4'd0, 4'd0, 3'd0, 4'd0, 32'd0);
        d = cp_rdata;
        v = cp_rvalid;
        cp_rready = 1'b1;
        cyc();
        cp_rready = 1'b0;
        dn = cp_done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        n_checks++;
        if ({cp_req_ready, cp_busy, cp_dat_ready} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_comb: got %b want 100",
                     {cp_req_ready, cp_busy, cp_dat_ready});
        end
        n_checks++;
        if ({cp_rvalid, cp_done, cp_absent} !== 3'b000 || cp_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_regs: got rv/dn/ab=%b rdata=%h want 000/0",
                     {cp_rvalid, cp_done, cp_absent}, cp_rdata);
        end
    endtask

    task automatic test_mcr_mrc();
        logic [31:0] d0;
        logic [31:0] d1;
        int dones;
        issue(OP_MCR, 4'd10, 4'd3, 4'd0, 4'd0, 3'd0, 4'd0, 32'hDEADBEEF);
        n_checks++;
        if (cp_done !== 1'b1 || cp_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mcr_done: got done=%b busy=%b want 1 0", cp_done, cp_busy);
        end
        issue(OP_MRC, 4'd10, 4'd3, 4'd0, 4'd0, 3'd0, 4'd0, 32'd0);
        d0 = cp_rdata;
        n_checks++;
        if (cp_rvalid !== 1'b1 || d0 !== 32'hDEADBEEF || cp_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mrc_data: got rv=%b rdata=%h rdy=%b want 1 deadbeef 0",
                     cp_rvalid, d0, cp_req_ready);
        end
        dones = 0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            if (cp_done) dones++;
            d1 = cp_rdata;
            n_checks++;
            if (cp_rvalid !== 1'b1 || d1 !== 32'hDEADBEEF) begin
                n_fail++;
                $display("FAIL mrc_stall: got rv=%b rdata=%h want 1 deadbeef",
                         cp_rvalid, d1);
            end
        end
        cp_rready = 1'b1;
        cyc();
        cp_rready = 1'b0;
        if (cp_done) dones++;
        n_checks++;
        if (cp_rvalid !== 1'b0 || cp_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mrc_release: got rv=%b rdy=%b want 0 1", cp_rvalid, cp_req_ready);
        end
        cyc();
        if (cp_done) dones++;
        n_checks++;
        if (dones !== 1) begin
            n_fail++;
            $display("FAIL mrc_done_count: got %0d want 1", dones);
        end
    endtask

    task automatic test_cdp();
        logic [31:0] d;
        logic v, dn;
        int busy_n;
        logic done_seen;
        issue(OP_MCR, 4'd10, 4'd1, 4'd0, 4'd0, 3'd0, 4'd0, 32'd7);
        issue(OP_MCR, 4'd10, 4'd2, 4'd0, 4'd0, 3'd0, 4'd0, 32'd5);
        issue(OP_CDP, 4'd10, 4'd4, 4'd1, 4'd2, 3'd5, 4'd0, 32'd0);
        busy_n = 0;
        for (int i = 0; i < 10; i++) begin
            if (!cp_busy) break;
            busy_n++;
            cyc();
        end
        done_seen = cp_done;
        n_checks++;
        if (busy_n !== 3 || done_seen !== 1'b1) begin
            n_fail++;
            $display("FAIL cdp_busy: got busy=%0d done=%b want 3 1", busy_n, done_seen);
        end
        cyc();
        mrc(4'd4, d, v, dn);
        n_checks++;
        if (d !== 32'd35 || v !== 1'b1 || dn !== 1'b1) begin
            n_fail++;
            $display("FAIL cdp_mul: got %h v=%b dn=%b want 00000023 1 1", d, v, dn);
        end
        issue(OP_CDP, 4'd10, 4'd5, 4'd2, 4'd1, 3'd1, 4'd0, 32'd0);
        for (int i = 0; i < 10 && cp_busy; i++) cyc();
        mrc(4'd5, d, v, dn);
        n_checks++;
        if (d !== 32'hFFFFFFFE) begin
            n_fail++;
            $display("FAIL cdp_sub: got %h want fffffffe", d);
        end
        issue(OP_CDP, 4'd10, 4'd6, 4'd1, 4'd2, 3'd4, 4'd0, 32'd0);
        for (int i = 0; i < 10 && cp_busy; i++) cyc();
        mrc(4'd6, d, v, dn);
        n_checks++;
        if (d !== 32'd2) begin
            n_fail++;
            $display("FAIL cdp_eor: got %h want 00000002", d);
        end
    endtask

    task automatic test_ldc_stc();
        logic [31:0] d;
        logic v, dn;
        logic [3:0] idx;
        issue(OP_LDC, 4'd10, 4'd14, 4'd0, 4'd0, 3'd0, 4'd3, 32'd0);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (cp_dat_ready !== 1'b1 || cp_done !== 1'b0) begin
                n_fail++;
                $display("FAIL ldc_gap%0d: got rdy=%b done=%b want 1 0",
                         k, cp_dat_ready, cp_done);
            end
            cyc();
            cp_wdata = 32'(k + 1);
            cp_dat_valid = 1'b1;
            cyc();
            cp_dat_valid = 1'b0;
        end
        n_checks++;
        if (cp_done !== 1'b1 || cp_dat_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ldc_done: got done=%b rdy=%b want 1 0", cp_done, cp_dat_ready);
        end
        for (int k = 0; k < 4; k++) begin
            idx = 4'(14 + k);
            mrc(idx, d, v, dn);
            n_checks++;
            if (d !== 32'(k + 1)) begin
                n_fail++;
                $display("FAIL ldc_cr%0d: got %h want %h", idx, d, 32'(k + 1));
            end
        end
        issue(OP_STC, 4'd10, 4'd14, 4'd0, 4'd0, 3'd0, 4'd3, 32'd0);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) cyc();
            n_checks++;
            if (cp_rvalid !== 1'b1 || cp_rdata !== 32'(k + 1)) begin
                n_fail++;
                $display("FAIL stc_beat%0d: got rv=%b data=%h want 1 %h",
                         k, cp_rvalid, cp_rdata, 32'(k + 1));
            end
            cp_rready = 1'b1;
            cyc();
            cp_rready = 1'b0;
        end
        n_checks++;
        if (cp_done !== 1'b1 || cp_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL stc_done: got done=%b rv=%b want 1 0", cp_done, cp_rvalid);
        end
        cyc();
    endtask

    task automatic test_absent();
        logic [31:0] d;
        logic v, dn;
        issue(OP_MCR, 4'd9, 4'd3, 4'd0, 4'd0, 3'd0, 4'd0, 32'h12345678);
        n_checks++;
        if (cp_absent !== 1'b1 || cp_done !== 1'b0 || cp_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL absent_num: got ab=%b dn=%b rdy=%b want 1 0 1",
                     cp_absent, cp_done, cp_req_ready);
        end
        cyc();
        n_checks++;
        if (cp_absent !== 1'b0) begin
            n_fail++;
            $display("FAIL absent_pulse: got %b want 0", cp_absent);
        end
        mrc(4'd3, d, v, dn);
        n_checks++;
        if (d !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL absent_cr3: got %h want deadbeef", d);
        end
        issue(3'd6, 4'd10, 4'd3, 4'd0, 4'd0, 3'd0, 4'd0, 32'h0);
        n_checks++;
        if (cp_absent !== 1'b1 || cp_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL absent_op: got ab=%b busy=%b want 1 0", cp_absent, cp_busy);
        end
        cyc();
    endtask

    task automatic test_abort_cdp();
        logic [31:0] d;
        logic v, dn;
        int dones;
        issue(OP_CDP, 4'd10, 4'd4, 4'd3, 4'd0, 3'd6, 4'd0, 32'd0);
        cyc();
        cyc();
        cp_abort = 1'b1;
        cyc();
        cp_abort = 1'b0;
        dones = cp_done ? 1 : 0;
        n_checks++;
        if (cp_req_ready !== 1'b1 || cp_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got rdy=%b busy=%b want 1 0", cp_req_ready, cp_busy);
        end
        cyc();
        if (cp_done) dones++;
        n_checks++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL abort_done: got %0d pulses want 0", dones);
        end
        mrc(4'd4, d, v, dn);
        n_checks++;
        if (d !== 32'd35) begin
            n_fail++;
            $display("FAIL abort_cr4: got %h want 00000023", d);
        end
    endtask

    task automatic test_reset_mid_ldc();
        logic [31:0] d;
        logic v, dn;
        int nonzero;
        issue(OP_LDC, 4'd10, 4'd0, 4'd0, 4'd0, 3'd0, 4'd3, 32'd0);
        cp_dat_valid = 1'b1;
        cp_wdata = 32'hAA;
        cyc();
        cp_wdata = 32'hBB;
        cyc();
        cp_wdata = 32'hCC;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cp_dat_valid = 1'b0;
        n_checks++;
        if (cp_busy !== 1'b0 || cp_req_ready !== 1'b1 || cp_done !== 1'b0
            || cp_dat_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: got busy=%b rdy=%b done=%b drdy=%b want 0 1 0 0",
                     cp_busy, cp_req_ready, cp_done, cp_dat_ready);
        end
        nonzero = 0;
        for (int i = 0; i < 16; i++) begin
            mrc(4'(i), d, v, dn);
            if (d !== 32'd0) nonzero++;
        end
        n_checks++;
        if (nonzero !== 0) begin
            n_fail++;
            $display("FAIL rst_cr_clear: got %0d nonzero want 0", nonzero);
        end
    endtask

    initial begin
        test_reset();
        test_mcr_mrc();
        test_cdp();
        test_ldc_stc();
        test_absent();
        test_abort_cdp();
        test_reset_mid_ldc();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
